// File: rtl/sram_cmd_sequencer.sv
// AVR-side SRAM command sequencer: owns the SRAM address register and runs
// timed read/write strobe sequences with address auto-increment.
module sram_cmd_sequencer #(
    parameter int unsigned ADDR_WIDTH = 21,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WE_CYCLES  = 2,
    parameter int unsigned OE_CYCLES  = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  cmd_valid_i,
    input  logic [2:0]            cmd_code_i,
    output logic                  cmd_ready_o,
    input  logic                  si_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  cmd_err_o,
    output logic                  snes_mode_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_dout_o,
    output logic                  sram_dout_en_o,
    input  logic [DATA_WIDTH-1:0] sram_din_i,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o
);

    localparam int unsigned MAX_CYC = (WE_CYCLES > OE_CYCLES) ? WE_CYCLES : OE_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0] OP_SHIFT_ADDR = 3'd1;
    localparam logic [2:0] OP_CLR_ADDR   = 3'd2;
    localparam logic [2:0] OP_READ       = 3'd3;
    localparam logic [2:0] OP_WRITE      = 3'd4;
    localparam logic [2:0] OP_INC_ADDR   = 3'd5;
    localparam logic [2:0] OP_SET_SNES   = 3'd6;
    localparam logic [2:0] OP_CLR_SNES   = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_PULSE,
        RD_CAPTURE
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    ready_q;
    logic                    rd_valid_q;
    logic                    cmd_err_q;
    logic                    snes_q;
    logic                    ce_n_q;
    logic                    oe_n_q;
    logic                    we_n_q;
    logic                    dout_en_q;

    // Counter holds remaining pulse clocks minus one; reloaded on pulse-state entry.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rd_data_q  <= '0;
            dout_q     <= '0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            snes_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dout_en_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        case (cmd_code_i)
                            OP_SHIFT_ADDR: addr_q <= {addr_q[ADDR_WIDTH-2:0], si_i};
                            OP_CLR_ADDR:   addr_q <= '0;
                            OP_INC_ADDR:   addr_q <= addr_q + ADDR_WIDTH'(1);
                            OP_SET_SNES:   snes_q <= 1'b1;
                            OP_CLR_SNES:   snes_q <= 1'b0;
                            OP_READ: begin
                                if (snes_q) begin
                                    cmd_err_q <= 1'b1;
                                end else begin
                                    state_q   <= RD_PULSE;
                                    cnt_q     <= CNT_W'(OE_CYCLES - 1);
                                    ce_n_q    <= 1'b0;
                                    oe_n_q    <= 1'b0;
                                    dout_en_q <= 1'b0;
                                    ready_q   <= 1'b0;
                                end
                            end
                            OP_WRITE: begin
                                if (snes_q) begin
                                    cmd_err_q <= 1'b1;
                                end else begin
                                    state_q   <= WR_SETUP;
                                    dout_q    <= wr_data_i;
                                    ce_n_q    <= 1'b0;
                                    dout_en_q <= 1'b1;
                                    ready_q   <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    cnt_q   <= CNT_W'(WE_CYCLES - 1);
                    we_n_q  <= 1'b0;
                end
                WR_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q <= WR_HOLD;
                        we_n_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    state_q   <= IDLE;
                    ce_n_q    <= 1'b1;
                    dout_en_q <= 1'b0;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                    ready_q   <= 1'b1;
                end
                RD_PULSE: begin
                    if (cnt_q == '0) begin
                        state_q    <= RD_CAPTURE;
                        rd_data_q  <= sram_din_i;
                        rd_valid_q <= 1'b1;
                        oe_n_q     <= 1'b1;
                        ce_n_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RD_CAPTURE: begin
                    state_q <= IDLE;
                    addr_q  <= addr_q + ADDR_WIDTH'(1);
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready_o    = ready_q;
    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign cmd_err_o      = cmd_err_q;
    assign snes_mode_o    = snes_q;
    assign sram_addr_o    = addr_q;
    assign sram_dout_o    = dout_q;
    assign sram_dout_en_o = dout_en_q;
    assign sram_ce_n_o    = ce_n_q;
    assign sram_oe_n_o    = oe_n_q;
    assign sram_we_n_o    = we_n_q;

endmodule

// File: doc/sram_cmd_sequencer.md
Name: sram_cmd_sequencer

Overview:
Upstream command stage for the CPLD SRAM bus. It accepts 3-bit AVR commands over a valid/ready handshake and owns the 21-bit SRAM address register (serial load, clear, increment). It generates timed SRAM read/write cycles with auto-increment and returns read data to the AVR side. Its outputs feed the SRAM pins and the SNES/AVR bus mux.

Parameters:
ADDR_WIDTH, 21, SRAM address width; the address wraps modulo 2^ADDR_WIDTH.
DATA_WIDTH, 8, SRAM/AVR data width.
WE_CYCLES, 2, number of clocks sram_we_n is held low (≥1).
OE_CYCLES, 2, number of clocks sram_oe_n is held low before capture (≥1).

Ports:
clk  in  1  single system clock; all state changes on rising edge.
reset_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command present.
cmd_code  in  3  command opcode.
cmd_ready  out  1  block can accept a command.
si  in  1  serial address bit, sampled with SHIFT_ADDR.
wr_data  in  DATA_WIDTH  write data, latched when WRITE is accepted.
rd_data  out  DATA_WIDTH  last read result.
rd_valid  out  1  one-clock pulse when rd_data updates.
cmd_err  out  1  one-clock pulse when READ/WRITE is rejected.
snes_mode  out  1  SRAM bus handed to SNES.
sram_addr  out  ADDR_WIDTH  SRAM address.
sram_dout  out  DATA_WIDTH  data driven to SRAM.
sram_dout_en  out  1  tristate enable for sram_dout.
sram_din  in  DATA_WIDTH  data from SRAM.
sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (async, reset_n=0): sram_addr=0, rd_data=0, rd_valid=0, cmd_err=0, snes_mode=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_dout_en=0, sram_dout=0, state=IDLE. Takes effect immediately, including mid-cycle. cmd_ready=1 on the first clock after release.
- Accept: cmd_valid & cmd_ready at a rising edge. cmd_ready=1 only in IDLE.
- Opcodes:
  - 0 NOP.
  - 1 SHIFT_ADDR: addr <= {addr[ADDR_WIDTH-2:0], si}. Shifts MSB first.
  - 2 CLR_ADDR: addr <= 0.
  - 3 READ.
  - 4 WRITE.
  - 5 INC_ADDR: addr <= addr+1.
  - 6 SET_SNES: snes_mode <= 1.
  - 7 CLR_SNES: snes_mode <= 0.
- Single-cycle opcodes (0,1,2,5,6,7) complete on the accept edge. The block stays in IDLE, so back-to-back accepts are allowed every clock.
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RD_CAPTURE.
- WRITE accepted at edge T:
  - wr_data is latched into sram_dout.
  - WR_SETUP, 1 clk: ce_n=0, dout_en=1, we_n=1.
  - WR_PULSE, WE_CYCLES clks: we_n=0.
  - WR_HOLD, 1 clk: we_n=1, ce_n=0, dout_en=1.
  - On leaving WR_HOLD: addr+1, ce_n=1, dout_en=0, back to IDLE.
  - Busy for WE_CYCLES+2 clocks.
- READ accepted at edge T:
  - RD_PULSE, OE_CYCLES clks: ce_n=0, oe_n=0, dout_en=0.
  - sram_din is sampled at the edge ending the last RD_PULSE clock; rd_data updates at that edge.
  - RD_CAPTURE, 1 clk: rd_valid=1, oe_n=1, ce_n=1. On leaving: addr+1, back to IDLE.
  - rd_valid is high exactly OE_CYCLES+1 clocks after accept.
- sram_we_n and sram_oe_n are never low simultaneously. dout_en=0 whenever oe_n=0.
- snes_mode=1: READ/WRITE are accepted but start no bus cycle. cmd_err pulses for 1 clk, addr is unchanged, and all strobes stay high.
- Wrap-around: the address increment (INC_ADDR or post-increment) from 2^ADDR_WIDTH-1 gives 0.
- Counters: the pulse counter is sized for max(WE_CYCLES, OE_CYCLES) and is reloaded on entry to each pulse state.
- cmd_code is ignored when cmd_valid=0. The command input is not buffered; the AVR holds cmd_valid until it sees ready.

Test Plan:
1. Reset check: hold reset_n=0 with random inputs -> sram_addr=0, all strobes=1, dout_en=0, rd_valid=0, snes_mode=0. After release, cmd_ready=1 next clock.
2. Serial address load: CLR_ADDR, then 21×SHIFT_ADDR with si bits 0x12345 MSB first -> sram_addr=0x012345; no strobe activity.
3. Write timing (WE_CYCLES=2): addr=0x000010, WRITE wr_data=0xA5 ->
   - we_n low exactly clocks T+2..T+3;
   - dout=0xA5, dout_en=1 for T+1..T+4;
   - cmd_ready=0 for 4 clocks;
   - sram_addr=0x000011 afterwards.
4. Read timing (OE_CYCLES=2): sram_din=0x3C, READ at T -> oe_n low T+1..T+2, rd_data=0x3C with rd_valid=1 at T+3 only, addr+1. Run back-to-back READs with no gap beyond ready.
5. Wrap and SNES lockout:
   - addr=0x1FFFFF, INC_ADDR -> 0x000000.
   - SET_SNES then WRITE -> cmd_err 1-clk pulse, we_n/ce_n stay 1, addr unchanged.
   - CLR_SNES, then WRITE proceeds normally.
6. Reset mid-operation: assert reset_n during WR_PULSE -> we_n=1, ce_n=1, dout_en=0, addr=0 immediately (same cycle, async). After release: IDLE, cmd_ready=1, no residual pulse.
